bus_master_if: RTL and testbench

- Bus master interface between a CPU pipeline stage (instruction fetch or memory access) and the shared system bus.
- Requests the bus from the arbiter, issues a single-word access to the addressed slave (ROM, RAM, I/O), waits for the slave's active-low ready, and returns read data.
- Stalls the pipeline while the access is in flight and holds returned data while the pipeline itself is stalled.
- Sits directly upstream of the ROM block: it drives that block's CS_/As_/Addr through the bus decoder and consumes its RdData/Rdy_.

---
 rtl/bus_master_if.sv | 121 ++++++++++++
 tb/tb_bus_master_if.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_master_if.sv
// Single-word bus master: requests the shared bus, issues one strobed access,
// waits for the slave's ready and hands read data back to the pipeline.
//
// state  | meaning
// IDLE   | waiting for a pipeline strobe
// REQ    | bus requested, waiting for arbiter grant
// ACCESS | strobe issued, waiting for slave ready
// STALL  | access done, pipeline stalled; hold result, accept nothing
module bus_master_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 30
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              stall,
  input  logic              flush,
  output logic              busy,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_as_,
  input  logic              cpu_rw,
  input  logic [DATA_W-1:0] cpu_wr_data,
  output logic [DATA_W-1:0] cpu_rd_data,
  output logic              bus_req_,
  input  logic              bus_grnt_,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_as_,
  output logic              bus_rw,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACCESS = 2'd2,
    STALL  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_rw;
  logic [DATA_W-1:0] lat_wr_data;
  logic [DATA_W-1:0] rd_buf;
  logic              accept;
  logic              grant_go;
  logic              done;

  // flush only gates a new access; an access already on the bus always completes
  assign accept   = (state == IDLE) && !cpu_as_ && !flush;
  assign grant_go = (state == REQ) && !bus_grnt_;
  assign done     = (state == ACCESS) && !bus_rdy_;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (accept) state_nxt = REQ;
      REQ:    if (grant_go) state_nxt = ACCESS;
      ACCESS: if (done) state_nxt = stall ? STALL : IDLE;
      STALL:  if (!stall) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy        = 1'b0;
    cpu_rd_data = rd_buf;
    case (state)
      IDLE:   busy = accept;
      REQ:    busy = 1'b1;
      ACCESS: begin
        busy = bus_rdy_;
        if (!bus_rdy_) cpu_rd_data = bus_rd_data;
      end
      default: busy = 1'b0;
    endcase
  end

  // registered bus side; strobe is forced high on every ACCESS cycle so it is one cycle wide
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      bus_req_    <= 1'b1;
      bus_as_     <= 1'b1;
      bus_rw      <= 1'b1;
      bus_addr    <= '0;
      bus_wr_data <= '0;
      lat_addr    <= '0;
      lat_rw      <= 1'b1;
      lat_wr_data <= '0;
      rd_buf      <= '0;
    end else begin
      if (accept) begin
        bus_req_    <= 1'b0;
        lat_addr    <= cpu_addr;
        lat_rw      <= cpu_rw;
        lat_wr_data <= cpu_wr_data;
      end
      if (grant_go) begin
        bus_addr    <= lat_addr;
        bus_rw      <= lat_rw;
        bus_wr_data <= lat_wr_data;
        bus_as_     <= 1'b0;
      end
      if (state == ACCESS) bus_as_ <= 1'b1;
      if (done) begin
        bus_req_ <= 1'b1;
        if (bus_rw) rd_buf <= bus_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_bus_master_if.sv
// Self-checking bench for bus_master_if: table of accesses driven against an
// arbiter/slave model, expected bus transactions tracked in a scoreboard queue.
module tb_bus_master_if;

  logic        clk = 1'b0;
  logic        reset_;
  logic        stall, flush, busy;
  logic [29:0] cpu_addr;
  logic        cpu_as_, cpu_rw;
  logic [31:0] cpu_wr_data, cpu_rd_data;
  logic        bus_req_, bus_grnt_;
  logic [29:0] bus_addr;
  logic        bus_as_, bus_rw;
  logic [31:0] bus_wr_data, bus_rd_data;
  logic        bus_rdy_;

  always #5 clk = ~clk;

  bus_master_if #(.DATA_W(32), .ADDR_W(30)) dut (
    .clk(clk), .reset_(reset_), .stall(stall), .flush(flush), .busy(busy),
    .cpu_addr(cpu_addr), .cpu_as_(cpu_as_), .cpu_rw(cpu_rw),
    .cpu_wr_data(cpu_wr_data), .cpu_rd_data(cpu_rd_data),
    .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_addr(bus_addr),
    .bus_as_(bus_as_), .bus_rw(bus_rw), .bus_wr_data(bus_wr_data),
    .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_)
  );

  typedef struct {
    logic [29:0] addr;
    logic        rw;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gnt_dly;
    int          rdy_dly;
    int          stall_cyc;
    logic        flush_on;
    logic [31:0] exp_rd;
    int          exp_busy;
  } vec_t;

  typedef struct {
    logic [29:0] addr;
    logic        rw;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  vec_t        vecs[6];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_buf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    cpu_as_     = 1'b1;
    bus_grnt_   = 1'b1;
    bus_rdy_    = 1'b1;
    stall       = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic run_txn(input vec_t v);
    exp_t e;
    int   req_cnt = 0;
    int   rdy_cnt = 0;
    int   as_w = 0;
    int   busy_cnt = 0;
    bit   as_seen = 0;
    bit   done = 0;
    e.addr = v.addr; e.rw = v.rw; e.wdata = v.wdata; e.rdata = v.rdata;
    exp_q.push_back(e);
    @(posedge clk); #1;
    cpu_addr = v.addr; cpu_rw = v.rw; cpu_wr_data = v.wdata; cpu_as_ = 1'b0; flush = 1'b0;
    #1;
    chk("accept_busy", 32'(busy), 32'd1);
    if (busy) busy_cnt++;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      @(posedge clk); #1;
      cpu_as_ = 1'b1; cpu_addr = 30'($urandom); cpu_wr_data = $urandom; cpu_rw = ~v.rw;
      if (bus_as_ == 1'b0) begin
        as_w++; as_seen = 1; rdy_cnt = 0; bus_grnt_ = 1'b1;
        chk("strobe_addr", 32'(bus_addr), 32'(exp_q[0].addr));
        chk("strobe_rw", 32'(bus_rw), 32'(exp_q[0].rw));
        if (!exp_q[0].rw) chk("strobe_wdata", bus_wr_data, exp_q[0].wdata);
      end else if (as_seen) begin
        rdy_cnt++;
        chk("hold_addr", 32'(bus_addr), 32'(exp_q[0].addr));
        chk("hold_rw", 32'(bus_rw), 32'(exp_q[0].rw));
        if (!exp_q[0].rw) chk("hold_wdata", bus_wr_data, exp_q[0].wdata);
        if (rdy_cnt > v.rdy_dly) begin
          bus_rdy_ = 1'b0; bus_rd_data = v.rdata; stall = (v.stall_cyc > 0); done = 1;
        end
      end else begin
        chk("req_low", 32'(bus_req_), 32'd0);
        req_cnt++;
        bus_grnt_ = (req_cnt > v.gnt_dly) ? 1'b0 : 1'b1;
      end
      if (v.flush_on) flush = 1'b1;
      #1;
      if (done) begin
        e = exp_q.pop_front();
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_rd_data", cpu_rd_data, e.rdata);
      end else if (busy) begin
        busy_cnt++;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL txn_timeout: got no bus_rdy_ completion expected completion within 60 cycles");
      exp_q.delete();
      idle_inputs();
      return;
    end
    chk("busy_cycles", 32'(busy_cnt), 32'(v.exp_busy));
    chk("strobe_width", 32'(as_w), 32'd1);
    if (v.rw) exp_buf = v.rdata;
    for (int s = 1; s < v.stall_cyc; s++) begin
      @(posedge clk); #1;
      bus_rdy_ = 1'b1; bus_grnt_ = 1'b1; bus_rd_data = $urandom; flush = 1'b0; cpu_as_ = 1'b0;
      #1;
      chk("stall_busy", 32'(busy), 32'd0);
      chk("stall_req", 32'(bus_req_), 32'd1);
      chk("stall_rd_data", cpu_rd_data, exp_buf);
    end
    @(posedge clk); #1;
    bus_rdy_ = 1'b1; bus_grnt_ = 1'b1; bus_rd_data = $urandom;
    stall = 1'b0; flush = 1'b0; cpu_as_ = 1'b1;
    #1;
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_req", 32'(bus_req_), 32'd1);
    chk("post_as", 32'(bus_as_), 32'd1);
    chk("post_rd_data", cpu_rd_data, v.exp_rd);
  endtask

  initial begin
    //         addr          rw    wdata         rdata         gnt rdy stl flush exp_rd        busy
    vecs[0] = '{30'h0000010, 1'b1, 32'h0,        32'hDEADBEEF, 0,  0,  0,  1'b0, 32'hDEADBEEF, 3};
    vecs[1] = '{30'h3FFFFFFF, 1'b1, 32'h0,       32'h0BADF00D, 5,  2,  0,  1'b0, 32'h0BADF00D, 10};
    vecs[2] = '{30'h0002000, 1'b0, 32'h12345678, 32'hBAD0BAD0, 1,  3,  0,  1'b0, 32'h0BADF00D, 7};
    vecs[3] = '{30'h0000044, 1'b1, 32'h0,        32'hCAFEF00D, 0,  0,  4,  1'b0, 32'hCAFEF00D, 3};
    vecs[4] = '{30'h0000055, 1'b1, 32'h0,        32'h13579BDF, 0,  2,  0,  1'b1, 32'h13579BDF, 5};
    vecs[5] = '{30'h0000000, 1'b0, 32'hFFFFFFFF, 32'h55AA55AA, 0,  0,  0,  1'b0, 32'h13579BDF, 3};

    reset_ = 1'b0;
    idle_inputs();
    cpu_addr = '0; cpu_rw = 1'b1; cpu_wr_data = '0; bus_rd_data = '0;
    exp_buf = '0;
    #12;
    chk("rst_req", 32'(bus_req_), 32'd1);
    chk("rst_as", 32'(bus_as_), 32'd1);
    chk("rst_rw", 32'(bus_rw), 32'd1);
    chk("rst_addr", 32'(bus_addr), 32'd0);
    chk("rst_wdata", bus_wr_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_data", cpu_rd_data, 32'd0);
    reset_ = 1'b1;

    // flush beats a pipeline strobe in IDLE
    @(posedge clk); #1;
    cpu_as_ = 1'b0; flush = 1'b1; cpu_addr = 30'h123;
    #1;
    chk("flush_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1; #1;
      chk("flush_req", 32'(bus_req_), 32'd1);
      chk("flush_busy_hold", 32'(busy), 32'd0);
    end
    idle_inputs();

    // grant and ready outside REQ/ACCESS are ignored
    @(posedge clk); #1;
    bus_grnt_ = 1'b0; bus_rdy_ = 1'b0; bus_rd_data = 32'hFFFF0000;
    #1;
    chk("stray_rd_data", cpu_rd_data, exp_buf);
    chk("stray_busy", 32'(busy), 32'd0);
    @(posedge clk); #1; #1;
    chk("stray_as", 32'(bus_as_), 32'd1);
    chk("stray_rd_data2", cpu_rd_data, exp_buf);
    idle_inputs();

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // reset while waiting on a slave
    @(posedge clk); #1;
    cpu_as_ = 1'b0; cpu_addr = 30'h77; cpu_rw = 1'b1;
    @(posedge clk); #1;
    cpu_as_ = 1'b1; bus_grnt_ = 1'b0;
    @(posedge clk); #1;
    bus_grnt_ = 1'b1;
    chk("rma_strobe", 32'(bus_as_), 32'd0);
    @(posedge clk); #1;
    chk("rma_waiting", 32'(busy), 32'd1);
    bus_rdy_ = 1'b0; bus_rd_data = 32'h99999999; reset_ = 1'b0;
    #1;
    chk("rma_req", 32'(bus_req_), 32'd1);
    chk("rma_as", 32'(bus_as_), 32'd1);
    chk("rma_rd_data", cpu_rd_data, 32'd0);
    chk("rma_addr", 32'(bus_addr), 32'd0);
    chk("rma_busy", 32'(busy), 32'd0);
    exp_buf = '0;
    @(posedge clk); #1;
    reset_ = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus_grnt_ = i[0]; bus_rdy_ = ~i[0];
      #1;
      chk("rma_idle_req", 32'(bus_req_), 32'd1);
      chk("rma_idle_busy", 32'(busy), 32'd0);
      chk("rma_idle_data", cpu_rd_data, 32'd0);
    end
    idle_inputs();
    run_txn(vecs[0]);

    #20;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
